// File: rtl/loteria_emissor_if.sv
// Bus between the user-input side and the lottery bet transmitter.
// The master drives commands and the checker's win flag; the slave presents
// the digit/strobe interface towards the checker plus status.
interface loteria_emissor_if;
   logic [3:0] digit_in;
   logic       load;
   logic       start;
   logic       clear;
   logic       win_in;
   logic [3:0] num;
   logic       insert;
   logic       finish;
   logic       busy;
   logic       done;
   logic       won;
   logic [2:0] count;
   logic       err;

   modport master (
      output digit_in, load, start, clear, win_in,
      input  num, insert, finish, busy, done, won, count, err
   );

   modport slave (
      input  digit_in, load, start, clear, win_in,
      output num, insert, finish, busy, done, won, count, err
   );
endinterface

// File: rtl/loteria_emissor.sv
// Bet transmitter: buffers a bet digit by digit, replays it into the checker
// one digit per insert strobe, pulses finish, then samples the checker's win flag.
module loteria_emissor #(
   parameter int N_DIGITS    = 5,
   parameter int GAP         = 2,
   parameter int RESULT_WAIT = 3
) (
   input logic              clk,
   input logic              reset,
   loteria_emissor_if.slave bus
);

   localparam int GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;
   localparam int WAIT_W = $clog2(RESULT_WAIT + 1);

   localparam logic [2:0]        N_CNT    = 3'(N_DIGITS);
   localparam logic [GAP_W-1:0]  GAP_END  = GAP_W'((GAP > 0) ? (GAP - 1) : 0);
   localparam logic [WAIT_W-1:0] WAIT_END = WAIT_W'(RESULT_WAIT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
      S_GAP,
      S_FIN,
      S_WAIT,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        digit_buf_q [N_DIGITS];
   logic [3:0]        digit_buf_d [N_DIGITS];
   logic [2:0]        count_q, count_d;
   logic [2:0]        idx_q, idx_d;
   logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [3:0]        num_q, num_d;
   logic              insert_q, insert_d;
   logic              finish_q, finish_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              won_q, won_d;
   logic              err_q, err_d;

   // Next-state and next-output logic; only the highest-priority command
   // (clear, then start, then load) is acted on in any one cycle.
   always_comb begin
      state_d     = state_q;
      digit_buf_d = digit_buf_q;
      count_d     = count_q;
      idx_d       = idx_q;
      gap_cnt_d   = gap_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      num_d       = num_q;
      won_d       = won_q;
      insert_d    = 1'b0;
      finish_d    = 1'b0;
      err_d       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.clear) begin
               count_d = 3'd0;
               won_d   = 1'b0;
            end else if (bus.start) begin
               if (count_q == N_CNT) begin
                  idx_d   = 3'd0;
                  state_d = S_SEND;
               end else begin
                  err_d = 1'b1;
               end
            end else if (bus.load) begin
               if ((bus.digit_in <= 4'd9) && (count_q < N_CNT)) begin
                  digit_buf_d[count_q] = bus.digit_in;
                  count_d              = count_q + 3'd1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         S_SEND, S_GAP, S_FIN, S_WAIT: begin
            if (bus.clear) begin
               count_d = 3'd0;
               idx_d   = 3'd0;
               state_d = S_IDLE;
            end else begin
               if (bus.load || bus.start) begin
                  err_d = 1'b1;
               end
               case (state_q)
                  S_SEND: begin
                     if (idx_q < N_CNT) begin
                        num_d    = digit_buf_q[idx_q];
                        insert_d = 1'b1;
                        idx_d    = idx_q + 3'd1;
                        if (GAP == 0) begin
                           state_d = (idx_d < N_CNT) ? S_SEND : S_FIN;
                        end else begin
                           gap_cnt_d = '0;
                           state_d   = S_GAP;
                        end
                     end else begin
                        state_d = S_FIN;
                     end
                  end
                  S_GAP: begin
                     if (gap_cnt_q == GAP_END) begin
                        state_d = (idx_q < N_CNT) ? S_SEND : S_FIN;
                     end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                     end
                  end
                  S_FIN: begin
                     finish_d   = 1'b1;
                     wait_cnt_d = '0;
                     state_d    = S_WAIT;
                  end
                  default: begin
                     // The finish cycle itself is excluded from the result window.
                     if (wait_cnt_q == WAIT_END) begin
                        won_d   = bus.win_in;
                        state_d = S_DONE;
                     end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                     end
                  end
               endcase
            end
         end

         S_DONE: begin
            if (bus.clear) begin
               count_d = 3'd0;
               won_d   = 1'b0;
               state_d = S_IDLE;
            end else if (bus.start) begin
               won_d   = 1'b0;
               idx_d   = 3'd0;
               state_d = S_SEND;
            end else if (bus.load) begin
               err_d = 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_SEND) || (state_d == S_GAP) ||
               (state_d == S_FIN)  || (state_d == S_WAIT);
      done_d = (state_d == S_DONE);
   end

   // State, buffer and registered outputs; reset aborts everything immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         for (int i = 0; i < N_DIGITS; i++) begin
            digit_buf_q[i] <= 4'd0;
         end
         count_q    <= 3'd0;
         idx_q      <= 3'd0;
         gap_cnt_q  <= '0;
         wait_cnt_q <= '0;
         num_q      <= 4'd0;
         insert_q   <= 1'b0;
         finish_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         won_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         digit_buf_q <= digit_buf_d;
         count_q     <= count_d;
         idx_q       <= idx_d;
         gap_cnt_q   <= gap_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         num_q       <= num_d;
         insert_q    <= insert_d;
         finish_q    <= finish_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         won_q       <= won_d;
         err_q       <= err_d;
      end
   end

   assign bus.num    = num_q;
   assign bus.insert = insert_q;
   assign bus.finish = finish_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.won    = won_q;
   assign bus.count  = count_q;
   assign bus.err    = err_q;

endmodule

// File: tb/tb_loteria_emissor.sv
// Directed testbench for loteria_emissor with a small checker model that
// captures inserted digits and raises its win flag when the bet 5,0,9,6,7 is seen.
module tb_loteria_emissor;

   logic clk;
   logic reset;

   loteria_emissor_if bus();

   loteria_emissor #(
      .N_DIGITS   (5),
      .GAP        (2),
      .RESULT_WAIT(3)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;

   localparam int NCYC = 23;

   logic       rec_ins  [NCYC];
   logic       rec_fin  [NCYC];
   logic       rec_done [NCYC];
   logic       rec_won  [NCYC];
   logic       rec_busy [NCYC];
   logic [3:0] rec_num  [NCYC];

   logic [3:0] cap [5];
   int         cap_pos;
   logic       win_flag;

   // Clock generation
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Checker model: captures num on insert, decides the win flag on finish
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         cap_pos  <= 0;
         win_flag <= 1'b0;
      end else if (bus.insert) begin
         if (cap_pos < 5) begin
            cap[cap_pos] <= bus.num;
            cap_pos      <= cap_pos + 1;
         end
      end else if (bus.finish) begin
         win_flag <= (cap_pos == 5) && (cap[0] == 4'd5) && (cap[1] == 4'd0) &&
                     (cap[2] == 4'd9) && (cap[3] == 4'd6) && (cap[4] == 4'd7);
         cap_pos  <= 0;
      end
   end

   assign bus.win_in = win_flag;

   function automatic logic exp_ins(int c);
      return (c == 1) || (c == 4) || (c == 7) || (c == 10) || (c == 13);
   endfunction

   function automatic logic [3:0] exp_num(logic [19:0] bet, int c);
      int k;
      k = (c >= 13) ? 4 : (c - 1) / 3;
      return bet[19 - 4*k -: 4];
   endfunction

   // Called at a negedge; returns err and count seen after the load edge
   task automatic load_digit(input logic [3:0] d, output logic e, output logic [2:0] c);
      bus.digit_in = d;
      bus.load     = 1'b1;
      @(negedge clk);
      e        = bus.err;
      c        = bus.count;
      bus.load = 1'b0;
   endtask

   task automatic load_bet(input logic [19:0] bet);
      logic       e;
      logic [2:0] c;
      for (int k = 0; k < 5; k++) begin
         load_digit(bet[19 - 4*k -: 4], e, c);
      end
   endtask

   // Called at a negedge; start is sampled on the next edge (cycle 0)
   task automatic record_run();
      bus.start = 1'b1;
      @(posedge clk);
      for (int c = 0; c < NCYC; c++) begin
         @(negedge clk);
         if (c == 0) bus.start = 1'b0;
         rec_ins[c]  = bus.insert;
         rec_fin[c]  = bus.finish;
         rec_done[c] = bus.done;
         rec_won[c]  = bus.won;
         rec_busy[c] = bus.busy;
         rec_num[c]  = bus.num;
      end
   endtask

   task automatic test_reset();
      bus.digit_in = 4'd0;
      bus.load     = 1'b0;
      bus.start    = 1'b0;
      bus.clear    = 1'b0;
      reset        = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.num, bus.insert, bus.finish, bus.busy, bus.done, bus.won, bus.count, bus.err} !== 15'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %h expected 0",
                  {bus.num, bus.insert, bus.finish, bus.busy, bus.done, bus.won, bus.count, bus.err});
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.count !== 3'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_release: got count=%0d busy=%0b done=%0b expected 0 0 0",
                  bus.count, bus.busy, bus.done);
      end
   endtask

   task automatic test_win_bet();
      logic [19:0] bet;
      logic        e;
      logic [2:0]  c;
      bet = 20'h50967;
      for (int k = 0; k < 5; k++) begin
         load_digit(bet[19 - 4*k -: 4], e, c);
         checks++;
         if (e !== 1'b0 || c !== 3'(k + 1)) begin
            errors++;
            $display("[TB] FAIL win_load[%0d]: got err=%0b count=%0d expected err=0 count=%0d", k, e, c, k + 1);
         end
      end
      record_run();
      for (int i = 0; i < NCYC; i++) begin
         checks++;
         if (rec_ins[i] !== exp_ins(i) || rec_fin[i] !== (i == 16) ||
             rec_done[i] !== (i >= 20) || rec_busy[i] !== (i < 20) || rec_won[i] !== (i >= 20)) begin
            errors++;
            $display("[TB] FAIL win_strobes[c=%0d]: got ins=%0b fin=%0b done=%0b busy=%0b won=%0b expected %0b %0b %0b %0b %0b",
                     i, rec_ins[i], rec_fin[i], rec_done[i], rec_busy[i], rec_won[i],
                     exp_ins(i), (i == 16), (i >= 20), (i < 20), (i >= 20));
         end
         if (i >= 1) begin
            checks++;
            if (rec_num[i] !== exp_num(bet, i)) begin
               errors++;
               $display("[TB] FAIL win_num[c=%0d]: got %0d expected %0d", i, rec_num[i], exp_num(bet, i));
            end
         end
      end
   endtask

   task automatic test_replay();
      logic [19:0] bet;
      bet = 20'h50967;
      record_run();
      for (int i = 0; i < NCYC; i++) begin
         checks++;
         if (rec_ins[i] !== exp_ins(i) || rec_fin[i] !== (i == 16) ||
             rec_done[i] !== (i >= 20) || rec_won[i] !== (i >= 20)) begin
            errors++;
            $display("[TB] FAIL replay_strobes[c=%0d]: got ins=%0b fin=%0b done=%0b won=%0b expected %0b %0b %0b %0b",
                     i, rec_ins[i], rec_fin[i], rec_done[i], rec_won[i],
                     exp_ins(i), (i == 16), (i >= 20), (i >= 20));
         end
         if (i >= 1) begin
            checks++;
            if (rec_num[i] !== exp_num(bet, i)) begin
               errors++;
               $display("[TB] FAIL replay_num[c=%0d]: got %0d expected %0d", i, rec_num[i], exp_num(bet, i));
            end
         end
      end
   endtask

   task automatic test_clear_done();
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      checks++;
      if (bus.done !== 1'b0 || bus.count !== 3'd0 || bus.won !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL clear_done: got done=%0b count=%0d won=%0b busy=%0b err=%0b expected 0 0 0 0 0",
                  bus.done, bus.count, bus.won, bus.busy, bus.err);
      end
   endtask

   task automatic test_loss_bet();
      logic [19:0] bet;
      bet = 20'h12345;
      load_bet(bet);
      checks++;
      if (bus.count !== 3'd5) begin
         errors++;
         $display("[TB] FAIL loss_count: got %0d expected 5", bus.count);
      end
      record_run();
      for (int i = 0; i < NCYC; i++) begin
         checks++;
         if (rec_ins[i] !== exp_ins(i) || rec_fin[i] !== (i == 16) ||
             rec_done[i] !== (i >= 20) || rec_won[i] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL loss_strobes[c=%0d]: got ins=%0b fin=%0b done=%0b won=%0b expected %0b %0b %0b 0",
                     i, rec_ins[i], rec_fin[i], rec_done[i], rec_won[i], exp_ins(i), (i == 16), (i >= 20));
         end
         if (i >= 1) begin
            checks++;
            if (rec_num[i] !== exp_num(bet, i)) begin
               errors++;
               $display("[TB] FAIL loss_num[c=%0d]: got %0d expected %0d", i, rec_num[i], exp_num(bet, i));
            end
         end
      end
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
   endtask

   task automatic test_bad_digit();
      logic       e;
      logic [2:0] c;
      load_digit(4'd5, e, c);
      checks++;
      if (e !== 1'b0 || c !== 3'd1) begin
         errors++;
         $display("[TB] FAIL bad_digit_first: got err=%0b count=%0d expected err=0 count=1", e, c);
      end
      load_digit(4'd12, e, c);
      checks++;
      if (e !== 1'b1 || c !== 3'd1) begin
         errors++;
         $display("[TB] FAIL bad_digit_reject: got err=%0b count=%0d expected err=1 count=1", e, c);
      end
      @(negedge clk);
      checks++;
      if (bus.err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bad_digit_pulse: got err=%0b expected 0", bus.err);
      end
   endtask

   task automatic test_short_start();
      logic       e;
      logic [2:0] c;
      load_digit(4'd3, e, c);
      load_digit(4'd4, e, c);
      checks++;
      if (c !== 3'd3) begin
         errors++;
         $display("[TB] FAIL short_count: got %0d expected 3", c);
      end
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      checks++;
      if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL short_start: got err=%0b busy=%0b expected err=1 busy=0", bus.err, bus.busy);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (bus.insert !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL short_idle[%0d]: got ins=%0b busy=%0b err=%0b expected 0 0 0",
                     i, bus.insert, bus.busy, bus.err);
         end
      end
   endtask

   task automatic test_overflow();
      logic       e;
      logic [2:0] c;
      load_digit(4'd8, e, c);
      load_digit(4'd9, e, c);
      checks++;
      if (e !== 1'b0 || c !== 3'd5) begin
         errors++;
         $display("[TB] FAIL overflow_fill: got err=%0b count=%0d expected err=0 count=5", e, c);
      end
      load_digit(4'd6, e, c);
      checks++;
      if (e !== 1'b1 || c !== 3'd5) begin
         errors++;
         $display("[TB] FAIL overflow_sixth: got err=%0b count=%0d expected err=1 count=5", e, c);
      end
   endtask

   // Buffer here holds 5,3,4,8,9
   task automatic test_busy_reject();
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      bus.load     = 1'b1;
      bus.digit_in = 4'd1;
      @(negedge clk);
      bus.load = 1'b0;
      checks++;
      if (bus.err !== 1'b1 || bus.busy !== 1'b1 || bus.count !== 3'd5) begin
         errors++;
         $display("[TB] FAIL busy_load: got err=%0b busy=%0b count=%0d expected 1 1 5", bus.err, bus.busy, bus.count);
      end
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      checks++;
      if (bus.err !== 1'b1 || bus.insert !== 1'b1 || bus.num !== 4'd3) begin
         errors++;
         $display("[TB] FAIL busy_start: got err=%0b ins=%0b num=%0d expected 1 1 3", bus.err, bus.insert, bus.num);
      end
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      checks++;
      if (bus.insert !== 1'b0 || bus.busy !== 1'b0 || bus.count !== 3'd0 || bus.err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL busy_abort: got ins=%0b busy=%0b count=%0d err=%0b expected 0 0 0 0",
                  bus.insert, bus.busy, bus.count, bus.err);
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if (bus.insert !== 1'b0 || bus.finish !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_after_abort[%0d]: got ins=%0b fin=%0b done=%0b expected 0 0 0",
                     i, bus.insert, bus.finish, bus.done);
         end
      end
   endtask

   task automatic test_reset_mid();
      load_bet(20'h50967);
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (8) @(posedge clk);
      #2;
      checks++;
      if (bus.busy !== 1'b1 || bus.num !== 4'd9) begin
         errors++;
         $display("[TB] FAIL mid_before_reset: got busy=%0b num=%0d expected 1 9", bus.busy, bus.num);
      end
      #1 reset = 1'b0;
      #1;
      checks++;
      if ({bus.num, bus.insert, bus.finish, bus.busy, bus.done, bus.won, bus.count, bus.err} !== 15'd0) begin
         errors++;
         $display("[TB] FAIL mid_reset_outputs: got %h expected 0",
                  {bus.num, bus.insert, bus.finish, bus.busy, bus.done, bus.won, bus.count, bus.err});
      end
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if (bus.insert !== 1'b0 || bus.finish !== 1'b0 || bus.busy !== 1'b0 || bus.count !== 3'd0) begin
            errors++;
            $display("[TB] FAIL mid_after_release[%0d]: got ins=%0b fin=%0b busy=%0b count=%0d expected 0 0 0 0",
                     i, bus.insert, bus.finish, bus.busy, bus.count);
         end
      end
   endtask

   // Test sequence
   initial begin
      test_reset();
      test_win_bet();
      test_replay();
      test_clear_done();
      test_loss_bet();
      test_bad_digit();
      test_short_start();
      test_overflow();
      test_busy_reject();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
